// File: rtl/sensor_sampler_pkg.sv
// rtl/sensor_sampler_pkg.sv - shared states, channel numbers and frame constants for the sensor sampler
package sensor_sampler_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int RESULT_BITS = 12;

    localparam logic [1:0] CMD_PREFIX     = 2'b11;
    localparam logic [1:0] CH_VOLTAGE     = 2'd0;
    localparam logic [1:0] CH_CURRENT     = 2'd1;
    localparam logic [1:0] CH_TEMPERATURE = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CONVERT,
        SEQ_PUBLISH
    } seq_state_t;

    typedef enum logic [1:0] {
        XFER_IDLE,
        XFER_CS_SETUP,
        XFER_SHIFT,
        XFER_CS_GAP
    } xfer_state_t;

    // Start bit, single-ended bit, channel, then zero padding out to the frame length.
    function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [1:0] ch);
        return {CMD_PREFIX, ch, {(FRAME_BITS-4){1'b0}}};
    endfunction

endpackage

// File: rtl/sensor_sampler_spi_adc_xfer.sv
// rtl/sensor_sampler_spi_adc_xfer.sv - one 16-bit SPI ADC frame: CS setup, shift, CS gap
module spi_adc_xfer
    import sensor_sampler_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             ch,
    input  logic                   miso,
    output logic                   cs_n,
    output logic                   sclk,
    output logic                   mosi,
    output logic                   done,
    output logic [RESULT_BITS-1:0] result
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    xfer_state_t           state;
    logic [CW-1:0]         cnt;
    logic [3:0]            bits_left;
    logic [FRAME_BITS-1:0] tx;
    logic [RESULT_BITS-1:0] rx;

    assign mosi   = tx[FRAME_BITS-1];
    assign result = rx;
    // done marks the last CS gap cycle so the next frame can start with no dead cycle
    assign done   = (state == XFER_CS_GAP) && (cnt == CNT_LAST);

    // Frame engine: each phase lasts CLK_DIV cycles; MISO shifts in on the edge that raises SCLK
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= XFER_IDLE;
            cnt       <= '0;
            bits_left <= '0;
            tx        <= '0;
            rx        <= '0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
        end else begin
            case (state)
                XFER_IDLE: begin
                    if (start) begin
                        state <= XFER_CS_SETUP;
                        cnt   <= '0;
                        cs_n  <= 1'b0;
                        tx    <= build_cmd(ch);
                    end
                end
                XFER_CS_SETUP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        bits_left <= 4'(FRAME_BITS - 1);
                        state     <= XFER_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            rx   <= {rx[RESULT_BITS-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bits_left == '0) begin
                                state <= XFER_CS_GAP;
                                cs_n  <= 1'b1;
                                tx    <= '0;
                            end else begin
                                bits_left <= bits_left - 1'b1;
                                tx        <= {tx[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER_CS_GAP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (start) begin
                            state <= XFER_CS_SETUP;
                            cs_n  <= 1'b0;
                            tx    <= build_cmd(ch);
                        end else begin
                            state <= XFER_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= XFER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sensor_sampler.sv
// rtl/sensor_sampler.sv - sample timer, 3-channel ADC sequencing and publish; SENSOR_SAMPLER_AVG_EN averages 4 sequences
module sensor_sampler
    import sensor_sampler_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   overrun_clr,
    input  logic                   adc_miso,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    output logic                   adc_mosi,
    output logic [RESULT_BITS-1:0] voltage_out,
    output logic [RESULT_BITS-1:0] current_out,
    output logic [RESULT_BITS-1:0] temperature_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

    logic [TW-1:0]          timer;
    logic                   tick;
    seq_state_t             state;
    logic [1:0]             ch;
    logic [RESULT_BITS-1:0] cap_v;
    logic [RESULT_BITS-1:0] cap_c;
    logic                   xfer_start;
    logic                   xfer_done;
    logic [1:0]             xfer_ch;
    logic [RESULT_BITS-1:0] xfer_result;

`ifdef SENSOR_SAMPLER_AVG_EN
    logic [13:0] acc_v;
    logic [13:0] acc_c;
    logic [13:0] acc_t;
    logic [1:0]  seq_cnt;
    logic [13:0] sum_v;
    logic [13:0] sum_c;
    logic [13:0] sum_t;

    assign sum_v = acc_v + {2'b00, cap_v};
    assign sum_c = acc_c + {2'b00, cap_c};
    assign sum_t = acc_t + {2'b00, xfer_result};
`endif

    assign tick = enable && (timer == TIMER_LAST);

    // Sample timer: free-runs while enabled, held at zero otherwise
    always_ff @(posedge clk) begin
        if (!reset || !enable || timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Launch channel 0 on a tick, then chain channels 1 and 2 straight off the previous frame
    always_comb begin
        xfer_start = 1'b0;
        xfer_ch    = CH_VOLTAGE;
        if (state == SEQ_IDLE && tick) begin
            xfer_start = 1'b1;
        end else if (state == SEQ_CONVERT && xfer_done && ch != CH_TEMPERATURE) begin
            xfer_start = 1'b1;
            xfer_ch    = ch + 2'd1;
        end
    end

    // Sticky overrun: any tick outside IDLE (including the publish cycle); a set beats a clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (tick && state != SEQ_IDLE) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Sequencer: capture each channel result, then publish all three outputs together
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= SEQ_IDLE;
            ch              <= CH_VOLTAGE;
            cap_v           <= '0;
            cap_c           <= '0;
            busy            <= 1'b0;
            sample_valid    <= 1'b0;
            voltage_out     <= '0;
            current_out     <= '0;
            temperature_out <= '0;
`ifdef SENSOR_SAMPLER_AVG_EN
            acc_v           <= '0;
            acc_c           <= '0;
            acc_t           <= '0;
            seq_cnt         <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (tick) begin
                        state <= SEQ_CONVERT;
                        ch    <= CH_VOLTAGE;
                        busy  <= 1'b1;
                    end
                end
                SEQ_CONVERT: begin
                    if (xfer_done) begin
                        if (ch == CH_VOLTAGE) cap_v <= xfer_result;
                        if (ch == CH_CURRENT) cap_c <= xfer_result;
                        if (ch == CH_TEMPERATURE) begin
                            state <= SEQ_PUBLISH;
                            busy  <= 1'b0;
`ifdef SENSOR_SAMPLER_AVG_EN
                            seq_cnt <= seq_cnt + 2'd1;
                            if (seq_cnt == 2'd3) begin
                                voltage_out     <= sum_v[13:2];
                                current_out     <= sum_c[13:2];
                                temperature_out <= sum_t[13:2];
                                sample_valid    <= 1'b1;
                                acc_v           <= '0;
                                acc_c           <= '0;
                                acc_t           <= '0;
                            end else begin
                                acc_v <= sum_v;
                                acc_c <= sum_c;
                                acc_t <= sum_t;
                            end
`else
                            voltage_out     <= cap_v;
                            current_out     <= cap_c;
                            temperature_out <= xfer_result;
                            sample_valid    <= 1'b1;
`endif
                        end else begin
                            ch <= xfer_ch;
                        end
                    end
                end
                SEQ_PUBLISH: state <= SEQ_IDLE;
                default:     state <= SEQ_IDLE;
            endcase
        end
    end

    spi_adc_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .clk    (clk),
        .reset  (reset),
        .start  (xfer_start),
        .ch     (xfer_ch),
        .miso   (adc_miso),
        .cs_n   (adc_cs_n),
        .sclk   (adc_sclk),
        .mosi   (adc_mosi),
        .done   (xfer_done),
        .result (xfer_result)
    );

endmodule

// File: tb/tb_sensor_sampler.sv
// tb/tb_sensor_sampler.sv - directed bench for sensor_sampler with an SPI ADC model
module tb_sensor_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_en, a_clr, a_miso, a_cs_n, a_sclk, a_mosi, a_valid, a_busy, a_ovr;
    logic [11:0] a_v, a_c, a_t;
    logic        b_en, b_clr, b_miso, b_cs_n, b_sclk, b_mosi, b_valid, b_busy, b_ovr;
    logic [11:0] b_v, b_c, b_t;

    sensor_sampler u_a (
        .clk(clk), .reset(reset), .enable(a_en), .overrun_clr(a_clr), .adc_miso(a_miso),
        .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .adc_mosi(a_mosi),
        .voltage_out(a_v), .current_out(a_c), .temperature_out(a_t),
        .sample_valid(a_valid), .busy(a_busy), .overrun(a_ovr)
    );

    sensor_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200)) u_b (
        .clk(clk), .reset(reset), .enable(b_en), .overrun_clr(b_clr), .adc_miso(b_miso),
        .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .adc_mosi(b_mosi),
        .voltage_out(b_v), .current_out(b_c), .temperature_out(b_t),
        .sample_valid(b_valid), .busy(b_busy), .overrun(b_ovr)
    );

    assign b_miso = 1'b0;

    int total = 0;
    int bad   = 0;

    // ADC model for instance a: decodes the channel from MOSI, returns adc_data[ch] MSB first
    logic [11:0] adc_data [4];
    int          ma_n = 0;
    logic [15:0] ma_cmd = '0;
    logic [1:0]  ma_ch = '0;
    logic [3:0]  prefix_q [$];
    int          a_valid_cnt = 0;
    int          a_cs_falls = 0;
    int          b_cs_falls = 0;

    always @(negedge a_cs_n) begin
        ma_n       <= 0;
        ma_cmd     <= '0;
        a_cs_falls <= a_cs_falls + 1;
    end

    always @(posedge a_sclk) begin
        if (!a_cs_n) begin
            ma_cmd <= {ma_cmd[14:0], a_mosi};
            ma_n   <= ma_n + 1;
            if (ma_n == 3) ma_ch <= {ma_cmd[0], a_mosi};
        end
    end

    always @(posedge a_cs_n) begin
        if (ma_n == 16) prefix_q.push_back(ma_cmd[15:12]);
    end

    always_comb begin
        a_miso = 1'b0;
        if (ma_n >= 4 && ma_n < 16) a_miso = adc_data[ma_ch][4'(15 - ma_n)];
    end

    always @(negedge b_cs_n) b_cs_falls <= b_cs_falls + 1;

    always @(posedge clk) begin
        if (a_valid) a_valid_cnt <= a_valid_cnt + 1;
    end

    typedef struct {
        logic [11:0] d0, d1, d2;
        logic [11:0] ev, ec, et;
    } seq_vec_t;

    seq_vec_t vecs [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // sel: 0 a_busy high, 1 a_valid high, 2 b_busy high, 3 a_busy low; n = negedges waited or -1
    task automatic wait_cond(input int sel, input int limit, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = a_busy;
                1:       hit = a_valid;
                2:       hit = b_busy;
                default: hit = !a_busy;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic check_prefixes(input string tag);
        check({tag, "_frames"}, prefix_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_prefix%0d", tag, i),
                  (i < prefix_q.size()) ? 32'(prefix_q[i]) : 32'hFFFF, 32'hC + i);
        end
        prefix_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, vc, cf, bf;
        bit  sclk_seen;

        vecs[0] = '{12'hABC, 12'h123, 12'hFFF, 12'hABC, 12'h123, 12'hFFF};
        vecs[1] = '{12'h000, 12'h800, 12'h5A5, 12'h000, 12'h800, 12'h5A5};

        reset = 1'b0; a_en = 1'b1; a_clr = 1'b0; b_en = 1'b0; b_clr = 1'b0;
        for (int i = 0; i < 4; i++) adc_data[i] = '0;
        sclk_seen = 1'b0;

        // Reset held for 5 cycles with enable high
        repeat (5) begin
            @(negedge clk);
            if (a_sclk || !a_cs_n) sclk_seen = 1'b1;
        end
        check("rst_spi_activity", sclk_seen, 0);
        check("rst_cs_n", a_cs_n, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_mosi", a_mosi, 0);
        check("rst_voltage", a_v, 0);
        check("rst_current", a_c, 0);
        check("rst_temperature", a_t, 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_overrun", a_ovr, 0);
        prefix_q.delete();
        reset = 1'b1;

`ifndef SENSOR_SAMPLER_AVG_EN
        // Basic sequences from the vector table
        for (int i = 0; i < 2; i++) begin
            adc_data[0] = vecs[i].d0;
            adc_data[1] = vecs[i].d1;
            adc_data[2] = vecs[i].d2;
            wait_cond(0, 1200, n);
            check($sformatf("v%0d_busy_rise", i), n >= 0, 1);
            wait_cond(1, 500, n);
            check($sformatf("v%0d_valid_latency", i), n, 408);
            check($sformatf("v%0d_busy_at_valid", i), a_busy, 0);
            check($sformatf("v%0d_voltage", i), a_v, vecs[i].ev);
            check($sformatf("v%0d_current", i), a_c, vecs[i].ec);
            check($sformatf("v%0d_temperature", i), a_t, vecs[i].et);
            check_prefixes($sformatf("v%0d", i));
            step(1);
            check($sformatf("v%0d_valid_one_cycle", i), a_valid, 0);
            check($sformatf("v%0d_voltage_hold", i), a_v, vecs[i].ev);
        end

        // Reset during channel 1 shift
        wait_cond(0, 1200, n);
        check("mr_busy_rise", n >= 0, 1);
        step(180);
        reset = 1'b0;
        step(1);
        check("mr_cs_n", a_cs_n, 1);
        check("mr_sclk", a_sclk, 0);
        check("mr_voltage", a_v, 0);
        check("mr_current", a_c, 0);
        check("mr_temperature", a_t, 0);
        check("mr_busy", a_busy, 0);
        vc = a_valid_cnt;
        step(3);
        prefix_q.delete();
        reset = 1'b1;
        wait_cond(0, 1200, n);
        check("mr_restart_busy", n >= 0, 1);
        check("mr_no_publish", a_valid_cnt - vc, 0);
        check("mr_voltage_still_zero", a_v, 0);
        wait_cond(1, 500, n);
        check("mr_valid_latency", n, 408);
        check("mr_current_after", a_c, vecs[1].ec);
        check("mr_temperature_after", a_t, vecs[1].et);
        check_prefixes("mr");

        // Enable drops 50 cycles after a tick
        wait_cond(0, 1200, n);
        check("en_busy_rise", n >= 0, 1);
        step(49);
        a_en = 1'b0;
        wait_cond(1, 500, n);
        check("en_valid_latency", n, 359);
        check("en_temperature", a_t, vecs[1].et);
        cf = a_cs_falls;
        step(3000);
        check("en_no_cs_activity", a_cs_falls - cf, 0);
        check("en_busy_idle", a_busy, 0);
        prefix_q.delete();
`else
        // Averaging: channel 0 returns 100..103 over four sequences
        for (int i = 0; i < 4; i++) begin
            adc_data[0] = 12'(100 + i);
            adc_data[1] = 12'h200;
            adc_data[2] = 12'h010;
            wait_cond(0, 1200, n);
            check($sformatf("avg%0d_busy_rise", i), n >= 0, 1);
            wait_cond(3, 500, n);
            check($sformatf("avg%0d_seq_len", i), n, 408);
            check($sformatf("avg%0d_valid", i), a_valid, (i == 3) ? 1 : 0);
            check($sformatf("avg%0d_voltage", i), a_v, (i == 3) ? 101 : 0);
            check_prefixes($sformatf("avg%0d", i));
        end
        check("avg_current", a_c, 12'h200);
        check("avg_temperature", a_t, 12'h010);
        step(1);
        check("avg_valid_count", a_valid_cnt, 1);
        a_en = 1'b0;
`endif

        // Overrun on the 200-cycle instance
        b_en = 1'b1;
        wait_cond(2, 300, n);
        check("ovr_busy_rise", n >= 0, 1);
        bf = b_cs_falls;
        step(198);
        check("ovr_before_tick", b_ovr, 0);
        step(2);
        check("ovr_set", b_ovr, 1);
        step(50);
        b_clr = 1'b1;
        step(1);
        b_clr = 1'b0;
        check("ovr_cleared", b_ovr, 0);
        step(148);
        b_clr = 1'b1;
        step(1);
        b_clr = 1'b0;
        check("ovr_set_wins", b_ovr, 1);
        step(7);
        check("ovr_busy_before_end", b_busy, 1);
        step(1);
        check("ovr_busy_end", b_busy, 0);
`ifndef SENSOR_SAMPLER_AVG_EN
        check("ovr_valid_on_time", b_valid, 1);
`endif
        check("ovr_no_restart", b_cs_falls - bf, 2);
        b_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_sampler.md
# sensor_sampler

Front-end acquisition stage that drives an external 4-channel, 12-bit SPI ADC and supplies the registered voltage, current and temperature words consumed by `microcontroller`. On every sample-period tick it converts ADC channels 0, 1 and 2 in sequence and publishes all three words together with a one-cycle `sample_valid` strobe. It also flags sample ticks lost while a sequence is still running.

## Interface
- `CLK_DIV`, 4 — SCLK half-period in `clk` cycles (H); minimum 1.
- `SAMPLE_PERIOD`, 1000 — `clk` cycles between sample ticks; minimum 2.
- `clk` input 1 — sole clock; all logic on rising edge.
- `reset` input 1 — synchronous, active-low reset (asserted when 0).
- `enable` input 1 — high: sample timer runs; low: timer held at 0.
- `overrun_clr` input 1 — clears `overrun`.
- `adc_miso` input 1 — ADC serial data out.
- `adc_cs_n` output 1 — ADC chip select, active low.
- `adc_sclk` output 1 — ADC serial clock, idle low.
- `adc_mosi` output 1 — ADC serial command.
- `voltage_out` output 12 — channel 0 result; drives `microcontroller.voltage_in`.
- `current_out` output 12 — channel 1 result; drives `current_in`.
- `temperature_out` output 12 — channel 2 result; drives `temperature_in`.
- `sample_valid` output 1 — one-cycle pulse when the three outputs update.
- `busy` output 1 — high while a sequence is in progress.
- `overrun` output 1 — sticky flag: a tick arrived while `busy`.

## Operation
- Timer counts 0..SAMPLE_PERIOD-1 while `enable`=1. A tick fires on the cycle it reaches SAMPLE_PERIOD-1, then it wraps to 0. The first tick occurs SAMPLE_PERIOD cycles after `enable` rises.
- A tick in IDLE starts a sequence. A tick while `busy` is dropped and sets `overrun`.
- `overrun` is cleared by `overrun_clr`. If a set and a clear occur in the same cycle, the set wins.
- Sequencer states: IDLE → CS_SETUP → SHIFT → CS_GAP.
  - CS_GAP returns to CS_SETUP for the next channel, or after channel 2 goes to PUBLISH → IDLE.
  - Channel order is fixed: 0, 1, 2.
- Frame format: 16 bits, MSB first.
  - MOSI bits 15..12 = {1, 1, ch[1:0]} (start, single-ended, channel); bits 11..0 = 0.
  - MISO bits 11..0 = conversion result, MSB first; MISO bits 15..12 are ignored.
- Per bit, SCLK is low for H cycles with MOSI already valid, then high for H cycles. `adc_miso` is captured on the `clk` edge that drives SCLK high.
- Per channel, CS_SETUP holds `adc_cs_n`=0 and SCLK low for H cycles. CS_GAP holds `adc_cs_n`=1 for H cycles.
- PUBLISH lasts one cycle: it loads all three outputs from the per-channel capture registers and pulses `sample_valid`. Outputs hold their values between publishes.
- `enable` falling mid-sequence does not abort: the sequence completes and publishes, and no further ticks follow.
- No backpressure from downstream: `microcontroller` samples the outputs every cycle.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_mosi`=0, all data outputs 0, `sample_valid`=0, `busy`=0, `overrun`=0. The timer and capture registers are also cleared.
- Reset mid-frame takes effect on the next edge: CS is deasserted, the frame is abandoned, no publish occurs, and the sequence restarts from channel 0 on the next tick.
- One channel takes 34·H cycles; one sequence takes 102·H cycles.
- `busy` rises the cycle after the tick. `sample_valid` pulses 102·H+1 cycles after the tick; this is 409 cycles at the default `CLK_DIV`.
- `busy` falls in the same cycle that `sample_valid` pulses. A tick in that cycle counts as an overrun.

## Configuration
- `SENSOR_SAMPLER_AVG_EN` defined: each channel keeps a 14-bit accumulator.
  - The accumulators sum 4 consecutive sequences.
  - On the 4th sequence the outputs are loaded with sum >> 2 (truncated), `sample_valid` pulses, and the accumulators clear.
  - `sample_valid` therefore pulses every 4th sequence. Reset clears the accumulators and the sequence count.
- Undefined: each sequence publishes the raw 12-bit results; no accumulator logic is present.

## Structure
- `sensor_sampler_pkg` contents:
  - sequencer state enum;
  - channel index constants: voltage = 0, current = 1, temperature = 2;
  - command prefix constant `2'b11`;
  - frame length 16 and result width 12.
- Sub-module `spi_adc_xfer`:
  - one start-to-done 16-bit frame engine covering CS_SETUP, SHIFT and CS_GAP;
  - channel number in, 12-bit result out;
  - owns the SCLK divider.
- The top level owns the timer, channel sequencing, publish/average logic and the overrun flag.

## Test plan
- Reset: hold `reset`=0 for 5 cycles with `enable`=1 → all outputs at reset values; no SCLK activity.
- Basic sequence (defaults, ADC model returns 0xABC / 0x123 / 0xFFF) → MOSI prefixes are 1100, 1101, 1110. `sample_valid` pulses 409 cycles after the tick with `voltage_out`=0xABC, `current_out`=0x123, `temperature_out`=0xFFF.
- Overrun: `SAMPLE_PERIOD`=200 → the second tick lands while `busy`, so `overrun`=1 and that tick starts no sequence. `overrun_clr` clears the flag; `overrun_clr` asserted in the same cycle as a new overrun leaves `overrun`=1.
- Reset mid-frame: drop `reset` during channel 1 SHIFT → `adc_cs_n`=1 on the next edge, no `sample_valid`, outputs 0. The next sequence starts at channel 0.
- Enable deassert: drop `enable` 50 cycles after a tick → that sequence still publishes; no further `adc_cs_n` activity over 3·SAMPLE_PERIOD cycles.
- `SENSOR_SAMPLER_AVG_EN`: channel 0 returns 100, 101, 102, 103 over 4 sequences → exactly one `sample_valid`, on the 4th sequence, with `voltage_out`=101.
